// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

    // Control states of the iterative multiplier
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Recoded radix-4 digit selected from a multiplier bit triplet
    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } digit_t;

    // One recode step per digit pair of the (WIDTH+2)-bit extended multiplier
    function automatic int calc_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_recoder_r4.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a signed digit.
module booth_recoder_r4
    import booth_pkg::*;
(
    input  logic [2:0] i_triplet,
    output digit_t     o_digit,
    output logic       o_neg,
    output logic       o_shift
);

    // Triplet {b(2i+1), b(2i), b(2i-1)} -> digit in {-2,-1,0,+1,+2}
    always_comb begin
        o_digit = DIG_ZERO;
        o_neg   = 1'b0;
        o_shift = 1'b0;
        case (i_triplet)
            3'b001, 3'b010: o_digit = DIG_POS1;
            3'b011: begin
                o_digit = DIG_POS2;
                o_shift = 1'b1;
            end
            3'b100: begin
                o_digit = DIG_NEG2;
                o_neg   = 1'b1;
                o_shift = 1'b1;
            end
            3'b101, 3'b110: begin
                o_digit = DIG_NEG1;
                o_neg   = 1'b1;
            end
            default: o_digit = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier, signed or unsigned, one digit per clock.
//
// Handshake: start is accepted only in IDLE or in the DONE cycle; busy is high
// for every RUN cycle; done pulses for one cycle with product valid, and
// product then holds its value until a later operation completes or reset.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_m,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     m,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = calc_iter(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = 2 * WIDTH + 4;   // accumulator width
    localparam int HW   = WIDTH + 4;       // width of the adder slice

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [WIDTH+1:0]      r_m;            // extended multiplicand
    logic [WIDTH+2:0]      r_q;            // extended multiplier with implicit 0 below LSB
    logic [AW-1:0]         r_acc;
    logic [2*WIDTH-1:0]    r_product;
    logic                  r_busy;
    logic                  r_done;

    digit_t                w_digit;
    logic                  w_neg;
    logic                  w_shift;
    logic [HW-1:0]         w_m_ext;
    logic [HW-1:0]         w_mag;
    logic [HW-1:0]         w_addend;
    logic signed [AW-1:0]  w_acc_sh;
    logic [HW-1:0]         w_hi_sum;
    logic [AW-1:0]         w_acc_next;
    logic                  w_last;
    logic [WIDTH+1:0]      w_m_cap;
    logic [WIDTH+2:0]      w_q_cap;

    booth_recoder_r4 u_recoder (
        .i_triplet (r_q[2:0]),
        .o_digit   (w_digit),
        .o_neg     (w_neg),
        .o_shift   (w_shift)
    );

    // Operand extension at capture: sign- or zero-extend to WIDTH+2 bits
    always_comb begin
        w_m_cap = signed_m ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
        w_q_cap = signed_m ? {{2{q[WIDTH-1]}}, q, 1'b0} : {2'b00, q, 1'b0};
    end

    // One recode step: shift the accumulator right by 2, then add digit*M at
    // bit WIDTH; after ITER steps the earliest digit has reached weight 4^0.
    // Negative digits use the inverted magnitude plus a carry-in of 1.
    always_comb begin
        w_m_ext    = {{2{r_m[WIDTH+1]}}, r_m};
        w_mag      = '0;
        if (w_digit != DIG_ZERO) begin
            w_mag = w_shift ? {w_m_ext[HW-2:0], 1'b0} : w_m_ext;
        end
        w_addend   = w_neg ? ~w_mag : w_mag;
        w_acc_sh   = $signed(r_acc) >>> 2;
        w_hi_sum   = w_acc_sh[AW-1:WIDTH] + w_addend + {{(HW-1){1'b0}}, w_neg};
        w_acc_next = {w_hi_sum, w_acc_sh[WIDTH-1:0]};
        w_last     = (r_cnt == CW'(ITER - 1));
    end

    // Control FSM and datapath registers with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= w_m_cap;
                        r_q     <= w_q_cap;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_q   <= {{2{r_q[WIDTH+2]}}, r_q[WIDTH+2:2]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_next[2*WIDTH-1:0];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= w_m_cap;
                        r_q     <= w_q_cap;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq at WIDTH=32 and WIDTH=8.
module tb_booth_multiplier_seq;

  localparam int L32 = 18;  // start cycle -> done cycle, WIDTH=32
  localparam int L8  = 6;   // start cycle -> done cycle, WIDTH=8

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        start32, signed32, busy32, done32;
  logic [31:0] q32, m32;
  logic [63:0] product32;
  logic        start8, signed8, busy8, done8;
  logic [7:0]  q8, m8;
  logic [15:0] product8;

  booth_multiplier_seq #(.WIDTH(32)) dut32 (
    .clock    (clk),
    .reset    (rst),
    .start    (start32),
    .signed_m (signed32),
    .q        (q32),
    .m        (m32),
    .busy     (busy32),
    .done     (done32),
    .product  (product32)
  );

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock    (clk),
    .reset    (rst),
    .start    (start8),
    .signed_m (signed8),
    .q        (q8),
    .m        (m8),
    .busy     (busy8),
    .done     (done8),
    .product  (product8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp32_q[$];
  int          iss32_q[$];
  logic [63:0] exp8_q[$];
  int          iss8_q[$];
  logic [63:0] hold32 = '0;
  logic [63:0] hold8  = '0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Exact product of two w-bit operands, as a 2w-bit pattern
  function automatic logic [63:0] model(input int w, input logic s,
                                        input logic [31:0] qv, input logic [31:0] mv);
    longint one = 1;
    longint a, b, p;
    a = longint'(qv) & ((one << w) - 1);
    b = longint'(mv) & ((one << w) - 1);
    if (s && ((a >> (w - 1)) & 1) == 1) a = a - (one << w);
    if (s && ((b >> (w - 1)) & 1) == 1) b = b - (one << w);
    p = a * b;
    if (w < 32) p = p & ((one << (2 * w)) - 1);
    return p;
  endfunction

  // Compare process: busy, done and held product every cycle
  logic e_busy32, e_done32, e_busy8, e_done8;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy32 = (iss32_q.size() > 0) && (iss32_q[0] < cyc) && (cyc < iss32_q[0] + L32);
      e_done32 = (iss32_q.size() > 0) && (cyc == iss32_q[0] + L32);
      if (e_done32) begin
        hold32 = exp32_q.pop_front();
        void'(iss32_q.pop_front());
      end
      check("busy32", 64'(busy32), 64'(e_busy32));
      check("done32", 64'(done32), 64'(e_done32));
      check("product32", product32, hold32);

      e_busy8 = (iss8_q.size() > 0) && (iss8_q[0] < cyc) && (cyc < iss8_q[0] + L8);
      e_done8 = (iss8_q.size() > 0) && (cyc == iss8_q[0] + L8);
      if (e_done8) begin
        hold8 = exp8_q.pop_front();
        void'(iss8_q.pop_front());
      end
      check("busy8", 64'(busy8), 64'(e_busy8));
      check("done8", 64'(done8), 64'(e_done8));
      check("product8", {48'b0, product8}, hold8);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle; the scoreboard records it only if the
  // block is expected to accept it (idle, or in its done cycle).
  task automatic issue(input bit w8, input logic s, input logic [31:0] qv,
                       input logic [31:0] mv, input logic [63:0] expv);
    bit acc;
    if (w8) begin
      acc = !((iss8_q.size() > 0) && (iss8_q[$] < cyc) && (cyc < iss8_q[$] + L8));
      signed8 = s; q8 = qv[7:0]; m8 = mv[7:0]; start8 = 1'b1;
      if (acc) begin
        exp8_q.push_back(expv);
        iss8_q.push_back(cyc);
      end
    end else begin
      acc = !((iss32_q.size() > 0) && (iss32_q[$] < cyc) && (cyc < iss32_q[$] + L32));
      signed32 = s; q32 = qv; m32 = mv; start32 = 1'b1;
      if (acc) begin
        exp32_q.push_back(expv);
        iss32_q.push_back(cyc);
      end
    end
    tick();
    start8 = 1'b0;
    start32 = 1'b0;
    // operands are free to change once captured
    signed8 = 1'($urandom_range(0, 1)); q8 = 8'($urandom); m8 = 8'($urandom);
    signed32 = 1'($urandom_range(0, 1)); q32 = $urandom; m32 = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (exp32_q.size() == 0 && exp8_q.size() == 0) break;
      tick();
    end
    check("drain_timeout", 64'(exp32_q.size() + exp8_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic        rs;
  logic [31:0] rq, rm;

  initial begin
    rst = 1'b1;
    start32 = 1'b0; signed32 = 1'b0; q32 = '0; m32 = '0;
    start8 = 1'b0;  signed8 = 1'b0;  q8 = '0;  m8 = '0;
    tick();
    chk_en = 1'b1;   // reset state: busy=0, done=0, product=0
    tick();
    rst = 1'b0;
    tick();

    // pin the model itself
    check("model_u_ones32", model(32, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_s_min32", model(32, 1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    check("model_s_neg8", model(8, 1, 32'hFB, 32'h06), 64'hFFE2);

    // directed, WIDTH=32
    issue(0, 0, 32'd7, 32'd3, 64'h0000_0000_0000_0015);                    wait_idle();
    issue(0, 1, 32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2);             wait_idle();
    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);     wait_idle();
    issue(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);     wait_idle();
    issue(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);     wait_idle();
    issue(0, 0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);             wait_idle();
    issue(0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);     wait_idle();

    // start mid-RUN is ignored; first result unaffected
    issue(0, 0, 32'd100, 32'd200, 64'd20000);
    repeat (4) tick();
    issue(0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 64'h0);
    wait_idle();

    // back-to-back: start in the done cycle
    issue(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
    repeat (L32 - 1) tick();
    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_idle();

    // reset during RUN cycle 9: abandon, clear product, no done pulse
    issue(0, 0, 32'h1234_5678, 32'h9ABC_DEF0, model(32, 0, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp32_q.delete(); iss32_q.delete();
    exp8_q.delete();  iss8_q.delete();
    hold32 = '0; hold8 = '0;
    repeat (25) tick();

    // directed, WIDTH=8
    issue(1, 1, 32'h80, 32'h80, 64'h4000);  wait_idle();
    issue(1, 0, 32'hFF, 32'hFF, 64'hFE01);  wait_idle();
    issue(1, 1, 32'hFF, 32'hFF, 64'h0001);  wait_idle();
    issue(1, 1, 32'hFB, 32'h06, 64'hFFE2);  wait_idle();
    issue(1, 0, 32'h80, 32'h02, 64'h0100);  wait_idle();

    // random regression against the model
    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom_range(0, 1)); rq = $urandom; rm = $urandom;
      issue(0, rs, rq, rm, model(32, rs, rq, rm));
      wait_idle();
    end
    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom_range(0, 1)); rq = 32'($urandom_range(0, 255)); rm = 32'($urandom_range(0, 255));
      issue(1, rs, rq, rm, model(8, rs, rq, rm));
      wait_idle();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
